// File: rtl/mul_hilo_pkg.sv
// Shared definitions for the HI/LO multiply control stage: state encoding,
// default settle window and settle-counter width.
package mul_hilo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int CNT_W             = 4;

endpackage

// File: rtl/alu_mul.sv
// Combinational 32x32 signed multiplier using radix-4 Booth recoding.
// Produces the full 64-bit two's-complement product.
module alu_mul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  logic [32:0] b_x;
  logic [63:0] a_x;

  assign b_x = {b_i, 1'b0};
  assign a_x = {{32{a_i[31]}}, a_i};

  // NOTE: always_comb uses blocking assignments and gives every variable a
  // default before any branch, so no latch can be inferred.
  always_comb begin
    logic [63:0] acc;
    logic [63:0] pp;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      pp = '0;
      case (b_x[2*i +: 3])
        3'b001, 3'b010: pp = a_x;
        3'b011:         pp = a_x << 1;
        3'b100:         pp = -(a_x << 1);
        3'b101, 3'b110: pp = -a_x;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    p_o = acc;
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multi-cycle control around alu_mul: latches operands on start, waits out the
// settle window, then loads HI/LO and pulses done. Also takes direct HI/LO writes.
module mul_hilo_ctrl
  import mul_hilo_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] bus_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, lo_q;
  logic             done_q;
  logic [63:0]      prod;

  // The multiplier sees only the latched operands, so the multicycle path
  // starts at a_q/b_q and ends at the HI/LO D-inputs.
  alu_mul u_alu_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  // NOTE: sequential state uses non-blocking assignments only; where two
  // assignments hit the same register in one edge, the later one wins.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (hi_wr) hi_q <= bus_in;
      if (lo_wr) lo_q <= bus_in;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            cnt_q   <= CNT_LOAD;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Placed after the direct writes so the product wins a collision.
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == WAIT);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural transaction model.
module tb_mul_hilo_ctrl;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        clr_n, start, hi_wr, lo_wr;
  logic [31:0] op_a, op_b, bus_in;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Reference model: one pending multiply with a due cycle and its product.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_prod;
  bit          m_done = 1'b0, m_pend = 1'b0;
  int          m_due = 0, cyc = 0;

  mul_hilo_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .hi_wr  (hi_wr),
    .lo_wr  (lo_wr),
    .bus_in (bus_in),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction

  function automatic string dut_s();
    return $sformatf("hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
  endfunction

  function automatic string mdl_s();
    return $sformatf("hi=%h lo=%h busy=%b done=%b", m_hi, m_lo, m_pend, m_done);
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (!clr_n) begin
      m_hi   = '0;
      m_lo   = '0;
      m_pend = 1'b0;
    end else begin
      if (hi_wr) m_hi = bus_in;
      if (lo_wr) m_lo = bus_in;
      if (m_pend) begin
        if (cyc == m_due) begin
          {m_hi, m_lo} = m_prod;
          m_done = 1'b1;
          m_pend = 1'b0;
        end
      end else if (start) begin
        m_pend = 1'b1;
        m_due  = cyc + SETTLE;
        m_prod = ref_mul(op_a, op_b);
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SETTLE) tick();
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    bus_in = '0; op_a = '0; op_b = '0;
    tick(); tick();
    checks++;
    if ({hi, lo, busy, done} !== 66'b0) begin
      errors++; $display("FAIL reset_init: got %s, want all zero", dut_s());
    end
    clr_n = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1; bus_in = 32'hDEADBEEF;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
    checks++;
    if (hi !== 32'hDEADBEEF || lo !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reset_preload: got %s, want hi=lo=deadbeef", dut_s());
    end
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy_before: got busy=%b, want 1", busy);
    end
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    checks++;
    if ({hi, lo, busy, done} !== 66'b0) begin
      errors++; $display("FAIL reset_midwait: got %s, want all zero", dut_s());
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({hi, lo, busy, done} !== 66'b0) begin
        errors++; $display("FAIL reset_no_late_write cycle %0d: got %s, want all zero", k, dut_s());
      end
    end
  endtask

  task automatic test_basic();
    int busy_cnt = 0, done_cnt = 0;
    op_a = 32'd3; op_b = -32'sd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      checks++;
      if ({hi, lo, busy, done} !== {m_hi, m_lo, m_pend, m_done}) begin
        errors++; $display("FAIL basic_model cycle %0d: got %s, want %s", k, dut_s(), mdl_s());
      end
      if (k == 1) begin
        checks++;
        if (done !== 1'b0 || lo === 32'hFFFFFFF4) begin
          errors++; $display("FAIL basic_early cycle 1: got %s, want done=0 and old lo", dut_s());
        end
      end
      if (k == 2) begin
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF4 || done !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL basic_result: got %s, want hi=ffffffff lo=fffffff4 busy=0 done=1", dut_s());
        end
      end
      tick();
    end
    checks++;
    if (busy_cnt != 2 || done_cnt != 1) begin
      errors++; $display("FAIL basic_pulse_widths: got busy=%0d done=%0d cycles, want 2 and 1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_corners();
    issue(32'h80000000, 32'h80000000);
    checks++;
    if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
      errors++; $display("FAIL corner_min: got %s, want hi=40000000 lo=00000000", dut_s());
    end
    issue(32'h7FFFFFFF, 32'h7FFFFFFF);
    checks++;
    if (hi !== 32'h3FFFFFFF || lo !== 32'h00000001) begin
      errors++; $display("FAIL corner_max: got %s, want hi=3fffffff lo=00000001", dut_s());
    end
  endtask

  task automatic test_busy_ignore();
    int done_cnt = 0;
    tick();
    op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    tick();
    op_a = 32'd5; op_b = 32'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      done_cnt += int'(done);
      checks++;
      if ({hi, lo, busy, done} !== {m_hi, m_lo, m_pend, m_done}) begin
        errors++; $display("FAIL busy_ignore_model cycle %0d: got %s, want %s", k, dut_s(), mdl_s());
      end
      tick();
    end
    checks++;
    if (done_cnt != 1 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++; $display("FAIL busy_ignore: got %s done_pulses=%0d, want hi=0 lo=42 done_pulses=1", dut_s(), done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    op_a = 32'd2; op_b = 32'd2; start = 1'b1;
    tick();
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    repeat (SETTLE) tick();
    checks++;
    if (lo !== 32'd4 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %s, want lo=4 done=1", dut_s());
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    repeat (SETTLE) tick();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd1 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got %s, want hi=0 lo=1 done=1", dut_s());
    end
  endtask

  task automatic test_operand_stability();
    op_a = 32'd7; op_b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0; op_a = 32'd9;
    repeat (SETTLE) tick();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd14) begin
      errors++; $display("FAIL operand_stability: got %s, want hi=0 lo=14", dut_s());
    end
  endtask

  task automatic test_write_collision();
    op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SETTLE - 1) tick();
    hi_wr = 1'b1; bus_in = 32'h12345678;
    tick();
    hi_wr = 1'b0;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      errors++; $display("FAIL collision_load_edge: got %s, want hi=0 lo=6", dut_s());
    end
    lo_wr = 1'b1; bus_in = 32'hAA;
    tick();
    lo_wr = 1'b0;
    checks++;
    if (hi !== 32'd0 || lo !== 32'hAA) begin
      errors++; $display("FAIL collision_idle_write: got %s, want hi=0 lo=000000aa", dut_s());
    end
    op_a = 32'd4; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0; lo_wr = 1'b1; bus_in = 32'hFFFF;
    tick();
    lo_wr = 1'b0;
    checks++;
    if (lo !== 32'hFFFF || busy !== 1'b1) begin
      errors++; $display("FAIL collision_wait_write: got %s, want lo=0000ffff busy=1", dut_s());
    end
    repeat (SETTLE - 1) tick();
    checks++;
    if (lo !== 32'd20 || hi !== 32'd0) begin
      errors++; $display("FAIL collision_overwrite: got %s, want hi=0 lo=20", dut_s());
    end
  endtask

  task automatic test_random();
    logic [31:0] corners [4];
    corners[0] = 32'h80000000; corners[1] = 32'h7FFFFFFF;
    corners[2] = 32'hFFFFFFFF; corners[3] = 32'h00000000;
    for (int k = 0; k < 400; k++) begin
      clr_n  = ($urandom_range(0, 63) != 0);
      start  = ($urandom_range(0, 2) == 0);
      hi_wr  = ($urandom_range(0, 7) == 0);
      lo_wr  = ($urandom_range(0, 7) == 0);
      bus_in = $urandom;
      op_a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      op_b   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      tick();
      checks++;
      if ({hi, lo, busy, done} !== {m_hi, m_lo, m_pend, m_done}) begin
        errors++; $display("FAIL random cycle %0d: got %s, want %s", k, dut_s(), mdl_s());
      end
    end
    clr_n = 1'b1; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_busy_ignore();
    test_back_to_back();
    test_operand_stability();
    test_write_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
